mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: grants A (CPU) or B (loader) one memory access at a time,
// with a ready timeout. Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration instead of fixed A priority.
module mem_arbiter #(
  parameter int TMO_MAX = 15
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        A_REQ,
  input  logic        A_RW,
  input  logic [15:0] A_ADDR,
  input  logic [15:0] A_WDATA,
  output logic        A_ACK,
  input  logic        B_REQ,
  input  logic        B_RW,
  input  logic [15:0] B_ADDR,
  input  logic [15:0] B_WDATA,
  output logic        B_ACK,
  output logic [15:0] RDATA,
  output logic        ERR,
  output logic        MEM_EN,
  output logic        RW,
  output logic [15:0] MAR_OUT,
  output logic [15:0] MDR_OUT,
  input  logic [15:0] MEM_OUT,
  input  logic        R,
  output logic        GNT_B,
  output logic        BUSY,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_ACK     = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  state_t      state, state_n;
  logic        a_ack_n, b_ack_n, err_n, mem_en_n, rw_n, gnt_b_n, busy_n;
  logic [15:0] rdata_n, mar_n, mdr_n;
  logic [7:0]  cnt, cnt_n;
  logic        pick_b;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // last_a: the previous grant went to A, so B wins the next tie
  logic last_a, last_a_n;
  assign pick_b = B_REQ && (!A_REQ || last_a);
`else
  assign pick_b = B_REQ && !A_REQ;
`endif

  assign state_dbg = state;

  always_comb begin
    state_n  = state;
    a_ack_n  = A_ACK;
    b_ack_n  = B_ACK;
    err_n    = ERR;
    rdata_n  = RDATA;
    mem_en_n = MEM_EN;
    rw_n     = RW;
    mar_n    = MAR_OUT;
    mdr_n    = MDR_OUT;
    gnt_b_n  = GNT_B;
    cnt_n    = cnt;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_a_n = last_a;
`endif
    case (state)
      S_IDLE: begin
        if (A_REQ || B_REQ) begin
          gnt_b_n  = pick_b;
          rw_n     = pick_b ? B_RW    : A_RW;
          mar_n    = pick_b ? B_ADDR  : A_ADDR;
          mdr_n    = pick_b ? B_WDATA : A_WDATA;
          mem_en_n = 1'b1;
          cnt_n    = 8'd0;
          state_n  = S_ACCESS;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_a_n = !pick_b;
`endif
        end
      end
      S_ACCESS: begin
        if (R) begin
          mem_en_n = 1'b0;
          if (!RW) rdata_n = MEM_OUT;
          err_n    = 1'b0;
          a_ack_n  = !GNT_B;
          b_ack_n  = GNT_B;
          state_n  = S_ACK;
        end else if (cnt == 8'(TMO_MAX - 1)) begin
          // this cycle is the TMO_MAX-th without ready: abort with error
          mem_en_n = 1'b0;
          rdata_n  = 16'h0000;
          err_n    = 1'b1;
          a_ack_n  = !GNT_B;
          b_ack_n  = GNT_B;
          state_n  = S_ACK;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      S_ACK: begin
        a_ack_n = 1'b0;
        b_ack_n = 1'b0;
        err_n   = 1'b0;
        state_n = S_RECOVER;
      end
      default: begin
        // a stale ready from memory must clear before the next grant
        if (!R) begin
          gnt_b_n = 1'b0;
          state_n = S_IDLE;
        end
      end
    endcase
    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state   <= S_RECOVER;
      A_ACK   <= 1'b0;
      B_ACK   <= 1'b0;
      ERR     <= 1'b0;
      RDATA   <= 16'h0000;
      MEM_EN  <= 1'b0;
      RW      <= 1'b0;
      MAR_OUT <= 16'h0000;
      MDR_OUT <= 16'h0000;
      GNT_B   <= 1'b0;
      BUSY    <= 1'b1;
      cnt     <= 8'd0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_a  <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      A_ACK   <= a_ack_n;
      B_ACK   <= b_ack_n;
      ERR     <= err_n;
      RDATA   <= rdata_n;
      MEM_EN  <= mem_en_n;
      RW      <= rw_n;
      MAR_OUT <= mar_n;
      MDR_OUT <= mdr_n;
      GNT_B   <= gnt_b_n;
      BUSY    <= busy_n;
      cnt     <= cnt_n;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_a  <= last_a_n;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: synchronous memory model, ACK scoreboard and per-scenario tasks.
module tb_mem_arbiter;

  logic        i_Clk;
  logic        i_Rst_n;
  logic        A_REQ, A_RW, B_REQ, B_RW;
  logic [15:0] A_ADDR, A_WDATA, B_ADDR, B_WDATA;
  logic        A_ACK, B_ACK, ERR, MEM_EN, RW, GNT_B, BUSY, R;
  logic [15:0] RDATA, MAR_OUT, MDR_OUT, MEM_OUT;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  // scoreboard entry: {ERR, B_ACK, RDATA}
  logic [17:0] exp_q[$];

  mem_arbiter #(.TMO_MAX(15)) dut (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n),
    .A_REQ(A_REQ), .A_RW(A_RW), .A_ADDR(A_ADDR), .A_WDATA(A_WDATA), .A_ACK(A_ACK),
    .B_REQ(B_REQ), .B_RW(B_RW), .B_ADDR(B_ADDR), .B_WDATA(B_WDATA), .B_ACK(B_ACK),
    .RDATA(RDATA), .ERR(ERR), .MEM_EN(MEM_EN), .RW(RW), .MAR_OUT(MAR_OUT),
    .MDR_OUT(MDR_OUT), .MEM_OUT(MEM_OUT), .R(R), .GNT_B(GNT_B), .BUSY(BUSY),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial begin
    i_Clk = 1'b0;
    forever #5 i_Clk = ~i_Clk;
  end

  // synchronous memory: ready and data one cycle after MEM_EN
  logic [15:0] mem [0:65535];
  logic        r_model;
  int          r_mode;   // 0 = model, 1 = forced 0, 2 = forced 1
  initial begin
    r_model = 1'b0;
    MEM_OUT = 16'h0000;
    r_mode  = 0;
  end
  always @(posedge i_Clk) begin
    r_model <= MEM_EN;
    MEM_OUT <= mem[MAR_OUT];
    if (MEM_EN && RW) mem[MAR_OUT] <= MDR_OUT;
  end
  assign R = (r_mode == 1) ? 1'b0 : (r_mode == 2) ? 1'b1 : r_model;

  // scoreboard monitor
  always @(negedge i_Clk) begin
    if (i_Rst_n && (A_ACK || B_ACK)) begin
      checks++;
      if (A_ACK && B_ACK) begin
        errors++;
        $display("FAIL ack_onehot: A_ACK=%0b B_ACK=%0b required one", A_ACK, B_ACK);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: got {err,b,rdata}=%h required none", {ERR, B_ACK, RDATA});
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        if ({ERR, B_ACK, RDATA} !== e) begin
          errors++;
          $display("FAIL scoreboard: got {err,b,rdata}=%h required %h", {ERR, B_ACK, RDATA}, e);
        end
      end
    end
  end

  // driver tasks
  task automatic drive_req(input bit is_b, input bit rw, input logic [15:0] addr, input logic [15:0] wdata);
    if (is_b) begin
      B_RW = rw; B_ADDR = addr; B_WDATA = wdata; B_REQ = 1'b1;
    end else begin
      A_RW = rw; A_ADDR = addr; A_WDATA = wdata; A_REQ = 1'b1;
    end
  endtask

  task automatic wait_ack(input bit is_b, input int max_cycles);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < max_cycles && !seen; k++) begin
      @(negedge i_Clk);
      if (is_b ? B_ACK : A_ACK) begin
        seen = 1'b1;
        checks++;
        if (GNT_B !== is_b) begin
          errors++;
          $display("FAIL gnt_b_at_ack: got %0b required %0b", GNT_B, is_b);
        end
      end
    end
    if (is_b) B_REQ = 1'b0; else A_REQ = 1'b0;
    if (!seen) begin
      errors++;
      $display("FAIL ack_timeout: requester b=%0b no ACK within %0d cycles", is_b, max_cycles);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge i_Clk);
  endtask

  task automatic do_reset();
    @(negedge i_Clk);
    i_Rst_n = 1'b0;
    idle_cycles(2);
    i_Rst_n = 1'b1;
    idle_cycles(3);
  endtask

  task automatic test_reset();
    i_Rst_n = 1'b1;
    #3 i_Rst_n = 1'b0;
    #1;
    checks++;
    if ({MEM_EN, A_ACK, B_ACK, ERR, GNT_B, RW, BUSY} !== 7'b0000001) begin
      errors++;
      $display("FAIL reset_ctrl: got {en,aack,back,err,gntb,rw,busy}=%b required 0000001",
               {MEM_EN, A_ACK, B_ACK, ERR, GNT_B, RW, BUSY});
    end
    checks++;
    if ({RDATA, MAR_OUT, MDR_OUT} !== 48'h0) begin
      errors++;
      $display("FAIL reset_data: got rdata=%h mar=%h mdr=%h required 0", RDATA, MAR_OUT, MDR_OUT);
    end
    checks++;
    if (state_dbg !== 2'd3) begin
      errors++;
      $display("FAIL reset_state: got %0d required 3", state_dbg);
    end
    idle_cycles(2);
    i_Rst_n = 1'b1;
    idle_cycles(3);
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: BUSY got %0b required 0", BUSY);
    end
  endtask

  task automatic test_read_timing();
    bit exp_en[5]   = '{1, 1, 0, 0, 0};
    bit exp_ack[5]  = '{0, 0, 1, 0, 0};
    bit exp_busy[5] = '{1, 1, 1, 1, 0};
    @(negedge i_Clk);
    drive_req(1'b0, 1'b0, 16'h0003, 16'h0000);
    exp_q.push_back({1'b0, 1'b0, 16'h03FE});
    for (int k = 0; k < 5; k++) begin
      @(negedge i_Clk);
      checks++;
      if ({MEM_EN, A_ACK, BUSY} !== {exp_en[k], exp_ack[k], exp_busy[k]}) begin
        errors++;
        $display("FAIL read_timing edge%0d: got {en,ack,busy}=%b required %b", k,
                 {MEM_EN, A_ACK, BUSY}, {exp_en[k], exp_ack[k], exp_busy[k]});
      end
      if (k == 2) A_REQ = 1'b0;
    end
    idle_cycles(2);
  endtask

  task automatic test_write_read_b();
    @(negedge i_Clk);
    drive_req(1'b1, 1'b1, 16'h0100, 16'h1234);
    exp_q.push_back({1'b0, 1'b1, 16'h03FE});  // write leaves RDATA at the previous read
    wait_ack(1'b1, 20);
    idle_cycles(2);
    drive_req(1'b1, 1'b0, 16'h0100, 16'h0000);
    exp_q.push_back({1'b0, 1'b1, 16'h1234});
    wait_ack(1'b1, 20);
    idle_cycles(2);
  endtask

  task automatic test_arbitration();
    bit seen;
    do_reset();
    @(negedge i_Clk);
    drive_req(1'b0, 1'b0, 16'h0003, 16'h0000);
    drive_req(1'b1, 1'b0, 16'h0100, 16'h0000);
    exp_q.push_back({1'b0, 1'b0, 16'h03FE});
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_q.push_back({1'b0, 1'b1, 16'h1234});
`else
    exp_q.push_back({1'b0, 1'b0, 16'h03FE});
`endif
    exp_q.push_back({1'b0, 1'b0, 16'h03FE});
    for (int n = 0; n < 3; n++) begin
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge i_Clk);
        if (A_ACK || B_ACK) seen = 1'b1;
      end
      if (n == 2) begin
        A_REQ = 1'b0;
        B_REQ = 1'b0;
      end
      if (!seen) begin
        errors++;
        $display("FAIL arb_timeout: transaction %0d not acknowledged", n);
      end
    end
    A_REQ = 1'b0;
    B_REQ = 1'b0;
    idle_cycles(4);
  endtask

  task automatic test_timeout();
    int first_k;
    first_k = -1;
    r_mode = 1;
    @(negedge i_Clk);
    drive_req(1'b0, 1'b0, 16'h0003, 16'h0000);
    exp_q.push_back({1'b1, 1'b0, 16'h0000});
    for (int k = 0; k < 40 && first_k < 0; k++) begin
      @(negedge i_Clk);
      if (A_ACK) first_k = k;
    end
    A_REQ = 1'b0;
    r_mode = 2;
    checks++;
    if (first_k != 15) begin
      errors++;
      $display("FAIL timeout_latency: ACK after edge %0d required 15", first_k);
    end
    drive_req(1'b1, 1'b0, 16'h0100, 16'h0000);
    exp_q.push_back({1'b0, 1'b1, 16'h1234});
    for (int k = 0; k < 6; k++) begin
      @(negedge i_Clk);
      checks++;
      if (MEM_EN !== 1'b0 || BUSY !== 1'b1) begin
        errors++;
        $display("FAIL recover_hold cyc%0d: got en=%0b busy=%0b required en=0 busy=1", k, MEM_EN, BUSY);
      end
    end
    r_mode = 0;
    wait_ack(1'b1, 20);
    idle_cycles(2);
  endtask

  task automatic test_reset_mid_access();
    @(negedge i_Clk);
    drive_req(1'b0, 1'b0, 16'h0003, 16'h0000);
    idle_cycles(2);
    checks++;
    if (MEM_EN !== 1'b1) begin
      errors++;
      $display("FAIL access_before_reset: MEM_EN got %0b required 1", MEM_EN);
    end
    #2 i_Rst_n = 1'b0;
    A_REQ = 1'b0;
    #1;
    checks++;
    if ({MEM_EN, A_ACK, BUSY} !== 3'b001) begin
      errors++;
      $display("FAIL async_reset: got {en,ack,busy}=%b required 001", {MEM_EN, A_ACK, BUSY});
    end
    r_mode = 2;
    @(negedge i_Clk);
    i_Rst_n = 1'b1;
    drive_req(1'b0, 1'b0, 16'h0003, 16'h0000);
    exp_q.push_back({1'b0, 1'b0, 16'h03FE});
    for (int k = 0; k < 3; k++) begin
      @(negedge i_Clk);
      checks++;
      if (MEM_EN !== 1'b0) begin
        errors++;
        $display("FAIL stale_ready cyc%0d: MEM_EN got %0b required 0", k, MEM_EN);
      end
    end
    r_mode = 0;
    wait_ack(1'b0, 20);
    idle_cycles(2);
  endtask

  task automatic test_back_to_back();
    @(negedge i_Clk);
    drive_req(1'b1, 1'b0, 16'h0100, 16'h0000);
    exp_q.push_back({1'b0, 1'b1, 16'h1234});
    exp_q.push_back({1'b0, 1'b0, 16'h03FE});
    @(negedge i_Clk);
    checks++;
    if (GNT_B !== 1'b1) begin
      errors++;
      $display("FAIL b_grant: GNT_B got %0b required 1", GNT_B);
    end
    drive_req(1'b0, 1'b0, 16'h0003, 16'h0000);
    B_ADDR = 16'h0003 + 16'($urandom_range(1, 100));
    @(negedge i_Clk);
    checks++;
    if (MAR_OUT !== 16'h0100) begin
      errors++;
      $display("FAIL mar_hold: MAR_OUT got %h required 0100", MAR_OUT);
    end
    wait_ack(1'b1, 20);
    wait_ack(1'b0, 20);
    idle_cycles(3);
  endtask

  initial begin
    A_REQ = 1'b0; A_RW = 1'b0; A_ADDR = 16'h0; A_WDATA = 16'h0;
    B_REQ = 1'b0; B_RW = 1'b0; B_ADDR = 16'h0; B_WDATA = 16'h0;
    mem[16'h0003] = 16'h03FE;
    test_reset();
    test_read_timing();
    test_write_read_b();
    test_arbitration();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected ACKs never seen, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
